reg_file_sb: RTL

Eight-entry, 16-bit general-purpose register file with a per-register pending-write scoreboard. It terminates the write-back interface: it consumes the write-enable, 3-bit destination and 16-bit data produced at the end of the pipeline. It also serves the two ID-stage read ports and reports read-after-write hazards, so ID can stall until a pending result has landed.

---
 rtl/reg_file_sb_pkg.sv | 16 +
 rtl/reg_file_sb_sb_counter.sv | 34 +++
 rtl/reg_file_sb.sv | 91 +++++++++
 3 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared constants and types for the reg_file_sb register file and its
// pending-write scoreboard.
package reg_file_sb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef logic [1:0] sb_cnt_t;

  // Deepest in-flight writer count: one each in EX, MEM and WB.
  localparam sb_cnt_t SB_MAX  = 2'd3;
  localparam sb_cnt_t SB_ZERO = 2'd0;
  localparam sb_cnt_t SB_ONE  = 2'd1;

endpackage

// File: rtl/reg_file_sb_sb_counter.sv
// Saturating 2-bit up/down writer count for one register; err pulses for the
// cycle in which an increment at SB_MAX or a decrement at zero is requested.
module sb_counter
  import reg_file_sb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    inc,
  input  logic    dec,
  output sb_cnt_t cnt,
  output logic    err
);

  sb_cnt_t cnt_next;

  // A simultaneous issue and retire cancel out and are never an error.
  always_comb begin
    cnt_next = cnt;
    err      = 1'b0;
    if (inc && !dec) begin
      if (cnt == SB_MAX) err = 1'b1;
      else               cnt_next = cnt + SB_ONE;
    end else if (dec && !inc) begin
      if (cnt == SB_ZERO) err = 1'b1;
      else                cnt_next = cnt - SB_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= SB_ZERO;
    else     cnt <= cnt_next;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Eight-entry register file with per-register pending-write scoreboard and
// read-after-write hazard output. Optional write-back bypass: REGFILE_BYPASS_EN.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Reg_write_en,
  input  logic [ADDR_W-1:0]     Reg_write_dest,
  input  logic [DATA_W-1:0]     Reg_write_data,
  input  logic [ADDR_W-1:0]     rd_addr1,
  input  logic [ADDR_W-1:0]     rd_addr2,
  input  logic                  rd_use1,
  input  logic                  rd_use2,
  output logic [DATA_W-1:0]     rd_data1,
  output logic [DATA_W-1:0]     rd_data2,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_dest,
  output logic                  hazard,
  output logic [(1<<ADDR_W)-1:0] pending,
  output logic                  sb_err
);

  localparam int NR = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NR];
  logic [NR-1:1]     inc;
  logic [NR-1:1]     dec;
  logic [NR-1:1]     err_vec;
  sb_cnt_t           cnt [NR-1:1];
  logic [NR-1:0]     blocked;

  // R0 is held at zero by never being written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else if (Reg_write_en && Reg_write_dest != '0) begin
      regs[Reg_write_dest] <= Reg_write_data;
    end
  end

  assign pending[0] = 1'b0;
  assign blocked[0] = 1'b0;

  for (genvar r = 1; r < NR; r++) begin : g_sb
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(r);

    assign inc[r] = issue_en && (issue_dest == IDX);
    assign dec[r] = Reg_write_en && (Reg_write_dest == IDX);

    sb_counter u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[r]),
      .dec (dec[r]),
      .cnt (cnt[r]),
      .err (err_vec[r])
    );

    assign pending[r] = (cnt[r] != SB_ZERO);

`ifdef REGFILE_BYPASS_EN
    // The last outstanding writer landing this cycle is forwarded, so no stall.
    assign blocked[r] = pending[r] && !(dec[r] && cnt[r] == SB_ONE);
`else
    assign blocked[r] = pending[r];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sb_err <= 1'b0;
    else if (|err_vec) sb_err <= 1'b1;
  end

  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (Reg_write_en && Reg_write_dest == rd_addr1 && rd_addr1 != '0)
      rd_data1 = Reg_write_data;
    if (Reg_write_en && Reg_write_dest == rd_addr2 && rd_addr2 != '0)
      rd_data2 = Reg_write_data;
`endif
  end

  assign hazard = (rd_use1 && blocked[rd_addr1]) || (rd_use2 && blocked[rd_addr2]);

endmodule
